fpu_div_sf: RTL and testbench

Iterative binary32 floating-point divider, the inverse operation of the single-precision FP multiplier, and used alongside it in the FPU execute path. It computes Rs / Rt with a one-quotient-bit-per-cycle restoring divider, rounds to nearest-even, and flushes subnormals like the multiplier. A start/busy/done handshake and the shared `exHold` pipeline stall control the divider.

---
 rtl/fpu_div_sf.sv | 192 +++++++++++++++++++
 tb/tb_fpu_div_sf.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_sf.sv
// Iterative binary32 divider: restoring mantissa division (one quotient bit per
// cycle), round-to-nearest-even, subnormals flushed to zero, start/busy/done handshake.
module fpu_div_sf (
  input  logic        clock,
  input  logic        reset,
  input  logic        exHold,
  input  logic        regStart,
  input  logic [31:0] regValRs,
  input  logic [31:0] regValRt,
  output logic [31:0] regValRo,
  output logic        regBusy,
  output logic        regDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             stateReg, stateNext;
  logic        [24:0] remReg, remNext;
  logic        [23:0] divisorReg, divisorNext;
  logic        [25:0] quotReg, quotNext;
  logic        [4:0]  countReg, countNext;
  logic signed [9:0]  expDiffReg, expDiffNext;
  logic               signReg, signNext;
  logic        [31:0] resultReg, resultNext;

  // Operand classification, index 0 = dividend, index 1 = divisor
  logic [1:0][31:0] opVal;
  logic [1:0]       opZero;
  logic [1:0]       opInf;
  logic [1:0]       opNan;

  assign opVal = {regValRt, regValRs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : genClass
      assign opZero[gi] = (opVal[gi][30:23] == 8'h00);
      assign opInf[gi]  = (opVal[gi][30:23] == 8'hFF) && (opVal[gi][22:0] == 23'd0);
      assign opNan[gi]  = (opVal[gi][30:23] == 8'hFF) && (opVal[gi][22:0] != 23'd0);
    end
  endgenerate

  logic        startSign;
  logic        isSpecial;
  logic [31:0] specialVal;

  assign startSign = regValRs[31] ^ regValRt[31];

  always_comb begin
    isSpecial  = 1'b1;
    specialVal = 32'h7FC00000;
    if ((|opNan) || (&opZero) || (&opInf)) begin
      specialVal = 32'h7FC00000;
    end else if (opInf[0]) begin
      specialVal = {startSign, 8'hFF, 23'd0};
    end else if (opInf[1]) begin
      specialVal = {startSign, 31'd0};
    end else if (opZero[1]) begin
      specialVal = {startSign, 8'hFF, 23'd0};
    end else if (opZero[0]) begin
      specialVal = {startSign, 31'd0};
    end else begin
      isSpecial = 1'b0;
    end
  end

  // One restoring step: compare, conditionally subtract, shift left
  logic        remGeq;
  logic [24:0] remSel;

  assign remGeq = (remReg >= {1'b0, divisorReg});
  assign remSel = remGeq ? (remReg - {1'b0, divisorReg}) : remReg;

  // Normalisation and rounding of the finished quotient
  logic [23:0]        roundMant;
  logic               roundGuard;
  logic               roundSticky;
  logic               roundUp;
  logic signed [9:0]  expPre;
  logic signed [9:0]  expFinal;
  logic [24:0]        mantSum;
  logic [30:0]        magBits;
  logic [31:0]        roundResult;

  always_comb begin
    if (quotReg[25]) begin
      roundMant   = quotReg[25:2];
      roundGuard  = quotReg[1];
      roundSticky = quotReg[0] | (|remReg);
      expPre      = expDiffReg + 10'sd127;
    end else begin
      roundMant   = quotReg[24:1];
      roundGuard  = quotReg[0];
      roundSticky = |remReg;
      expPre      = expDiffReg + 10'sd126;
    end
    roundUp  = roundGuard & (roundSticky | roundMant[0]);
    mantSum  = {1'b0, roundMant} + {24'd0, roundUp};
    expFinal = expPre + $signed({9'd0, mantSum[24]});
    // The hidden bit (and a rounding carry) ripple straight into the exponent
    // field, so a carry-out yields mantissa 0 with the exponent bumped by one.
    magBits  = {expPre[7:0] - 8'd1, 23'd0} + {6'd0, mantSum};
    if (expFinal <= 10'sd0) begin
      roundResult = {signReg, 31'd0};
    end else if (expFinal >= 10'sd255) begin
      roundResult = {signReg, 8'hFF, 23'd0};
    end else begin
      roundResult = {signReg, magBits};
    end
  end

  logic accept;
  assign accept = regStart && !exHold && ((stateReg == IDLE) || (stateReg == DONE));

  always_comb begin
    stateNext   = stateReg;
    remNext     = remReg;
    divisorNext = divisorReg;
    quotNext    = quotReg;
    countNext   = countReg;
    expDiffNext = expDiffReg;
    signNext    = signReg;
    resultNext  = resultReg;
    if (!exHold) begin
      case (stateReg)
        IDLE, DONE: begin
          if (accept) begin
            if (isSpecial) begin
              resultNext = specialVal;
              stateNext  = DONE;
            end else begin
              remNext     = {2'b01, regValRs[22:0]};
              divisorNext = {1'b1, regValRt[22:0]};
              quotNext    = 26'd0;
              countNext   = 5'd0;
              expDiffNext = $signed({2'b00, regValRs[30:23]}) - $signed({2'b00, regValRt[30:23]});
              signNext    = startSign;
              stateNext   = DIV;
            end
          end else begin
            stateNext = IDLE;
          end
        end
        DIV: begin
          quotNext  = {quotReg[24:0], remGeq};
          remNext   = remSel << 1;
          countNext = countReg + 5'd1;
          if (countReg == 5'd25) begin
            stateNext = ROUND;
          end
        end
        ROUND: begin
          resultNext = roundResult;
          stateNext  = DONE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      remReg     <= 25'd0;
      divisorReg <= 24'd0;
      quotReg    <= 26'd0;
      countReg   <= 5'd0;
      expDiffReg <= 10'sd0;
      signReg    <= 1'b0;
      resultReg  <= 32'd0;
    end else begin
      stateReg   <= stateNext;
      remReg     <= remNext;
      divisorReg <= divisorNext;
      quotReg    <= quotNext;
      countReg   <= countNext;
      expDiffReg <= expDiffNext;
      signReg    <= signNext;
      resultReg  <= resultNext;
    end
  end

  assign regValRo = resultReg;
  assign regBusy  = (stateReg == DIV) || (stateReg == ROUND);
  assign regDone  = (stateReg == DONE);

endmodule

// File: tb/tb_fpu_div_sf.sv
// Directed bench for fpu_div_sf: normal, special, range, stall, ignore,
// back-to-back and asynchronous-reset scenarios with hand-computed results.
module tb_fpu_div_sf;

  logic        clock = 1'b0;
  logic        reset;
  logic        exHold;
  logic        regStart;
  logic [31:0] regValRs;
  logic [31:0] regValRt;
  logic [31:0] regValRo;
  logic        regBusy;
  logic        regDone;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  fpu_div_sf dut (
    .clock    (clock),
    .reset    (reset),
    .exHold   (exHold),
    .regStart (regStart),
    .regValRs (regValRs),
    .regValRt (regValRt),
    .regValRo (regValRo),
    .regBusy  (regBusy),
    .regDone  (regDone)
  );

  // Drives one divide from the current negedge; lat counts clock edges after
  // the accepting edge until regDone is seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int holdAt, input int holdLen, input int pokeAt,
                         output logic [31:0] res, output int lat,
                         output int busyCycles, output bit timedOut);
    regValRs = a;
    regValRt = b;
    regStart = 1'b1;
    exHold   = 1'b0;
    @(posedge clock);
    lat = 0;
    busyCycles = 0;
    timedOut = 1'b0;
    @(negedge clock);
    regStart = 1'b0;
    regValRs = 32'hDEADBEEF;
    regValRt = 32'h12345678;
    while (!regDone) begin
      if (lat >= 300) begin
        timedOut = 1'b1;
        break;
      end
      if (regBusy) busyCycles++;
      exHold = (holdAt >= 0) && (lat >= holdAt) && (lat < holdAt + holdLen);
      if (lat == pokeAt) begin
        regStart = 1'b1;
        regValRs = 32'h3F800000;
        regValRt = 32'h40400000;
      end else begin
        regStart = 1'b0;
      end
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    exHold   = 1'b0;
    regStart = 1'b0;
    res = regValRo;
    $display("div %h / %h -> %h after %0d edges, busy %0d cycles", a, b, res, lat, busyCycles);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({regValRo, regBusy, regDone} !== 34'd0) begin
      fails++;
      $display("FAIL reset_state: ro=%h busy=%b done=%b, required 0/0/0", regValRo, regBusy, regDone);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({regValRo, regBusy, regDone} !== 34'd0) begin
      fails++;
      $display("FAIL idle_after_reset: ro=%h busy=%b done=%b, required 0/0/0", regValRo, regBusy, regDone);
    end
  endtask

  task automatic test_normal();
    logic [31:0] va [5] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hC0C00000, 32'h40000000};
    logic [31:0] vb [5] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] ve [5] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'hC0400000, 32'h40000000};
    logic [31:0] res;
    int lat, busy;
    bit to;
    for (int i = 0; i < 5; i++) begin
      run_div(va[i], vb[i], -1, 0, -1, res, lat, busy, to);
      checks++;
      if (to || res !== ve[i]) begin
        fails++;
        $display("FAIL normal_result[%0d]: got %h timeout=%b, required %h", i, res, to, ve[i]);
      end
      checks++;
      if (lat !== 27 || busy !== 27) begin
        fails++;
        $display("FAIL normal_latency[%0d]: latency %0d busy %0d, required 27/27", i, lat, busy);
      end
      @(negedge clock);
      checks++;
      if (regDone !== 1'b0 || regValRo !== ve[i]) begin
        fails++;
        $display("FAIL done_one_cycle[%0d]: done=%b ro=%h, required 0 and %h", i, regDone, regValRo, ve[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [6] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'h7FC01234};
    logic [31:0] vb [6] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'hFF800000, 32'h3F800000};
    logic [31:0] ve [6] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h7FC00000};
    logic [31:0] res;
    int lat, busy;
    bit to;
    for (int i = 0; i < 6; i++) begin
      run_div(va[i], vb[i], -1, 0, -1, res, lat, busy, to);
      checks++;
      if (to || res !== ve[i]) begin
        fails++;
        $display("FAIL special_result[%0d]: got %h timeout=%b, required %h", i, res, to, ve[i]);
      end
      checks++;
      if (lat !== 0 || busy !== 0) begin
        fails++;
        $display("FAIL special_fast_path[%0d]: latency %0d busy %0d, required 0/0", i, lat, busy);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_range();
    logic [31:0] va [3] = '{32'h00800000, 32'h7F000000, 32'h80800000};
    logic [31:0] vb [3] = '{32'h40000000, 32'h3E800000, 32'h40000000};
    logic [31:0] ve [3] = '{32'h00000000, 32'h7F800000, 32'h80000000};
    logic [31:0] res;
    int lat, busy;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], -1, 0, -1, res, lat, busy, to);
      checks++;
      if (to || res !== ve[i] || lat !== 27) begin
        fails++;
        $display("FAIL range[%0d]: got %h latency %0d, required %h latency 27", i, res, lat, ve[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_hold();
    logic [31:0] res;
    int lat, busy;
    bit to;
    // Hold must block acceptance
    regValRs = 32'h40C00000;
    regValRt = 32'h40000000;
    regStart = 1'b1;
    exHold   = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (regBusy !== 1'b0 || regDone !== 1'b0) begin
      fails++;
      $display("FAIL hold_blocks_start: busy=%b done=%b, required 0/0", regBusy, regDone);
    end
    regStart = 1'b0;
    exHold   = 1'b0;
    @(negedge clock);
    run_div(32'h40C00000, 32'h40000000, 8, 5, -1, res, lat, busy, to);
    checks++;
    if (to || res !== 32'h40400000 || lat !== 32) begin
      fails++;
      $display("FAIL hold_mid_div: got %h latency %0d, required 40400000 latency 32", res, lat);
    end
    exHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (regDone !== 1'b1 || regValRo !== 32'h40400000) begin
        fails++;
        $display("FAIL done_held[%0d]: done=%b ro=%h, required 1 and 40400000", i, regDone, regValRo);
      end
    end
    exHold = 1'b0;
    @(negedge clock);
    checks++;
    if (regDone !== 1'b0) begin
      fails++;
      $display("FAIL done_after_release: done=%b, required 0", regDone);
    end
  endtask

  task automatic test_ignore();
    logic [31:0] res;
    int lat, busy;
    bit to;
    run_div(32'h40C00000, 32'h40000000, -1, 0, 5, res, lat, busy, to);
    checks++;
    if (to || res !== 32'h40400000 || lat !== 27) begin
      fails++;
      $display("FAIL start_ignored_in_div: got %h latency %0d, required 40400000 latency 27", res, lat);
    end
    @(negedge clock);
    checks++;
    if (regBusy !== 1'b0 || regDone !== 1'b0) begin
      fails++;
      $display("FAIL no_restart_after_ignore: busy=%b done=%b, required 0/0", regBusy, regDone);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, busy;
    bit to;
    run_div(32'h40C00000, 32'h40000000, -1, 0, -1, res, lat, busy, to);
    checks++;
    if (to || res !== 32'h40400000) begin
      fails++;
      $display("FAIL b2b_first: got %h, required 40400000", res);
    end
    // Still in the done cycle: start the next one without a bubble
    run_div(32'h3F800000, 32'h40400000, -1, 0, -1, res, lat, busy, to);
    checks++;
    if (to || res !== 32'h3EAAAAAB || lat !== 27) begin
      fails++;
      $display("FAIL b2b_second: got %h latency %0d, required 3EAAAAAB latency 27", res, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat, busy;
    bit to;
    regValRs = 32'h40C00000;
    regValRt = 32'h40000000;
    regStart = 1'b1;
    @(posedge clock);
    @(negedge clock);
    regStart = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    checks++;
    if (regBusy !== 1'b1 || regValRo === 32'd0) begin
      fails++;
      $display("FAIL busy_before_reset: busy=%b ro=%h, required 1 and nonzero", regBusy, regValRo);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({regValRo, regBusy, regDone} !== 34'd0) begin
      fails++;
      $display("FAIL async_reset: ro=%h busy=%b done=%b, required 0/0/0", regValRo, regBusy, regDone);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_div(32'h3F800000, 32'h40400000, -1, 0, -1, res, lat, busy, to);
    checks++;
    if (to || res !== 32'h3EAAAAAB || lat !== 27) begin
      fails++;
      $display("FAIL after_reset_div: got %h latency %0d, required 3EAAAAAB latency 27", res, lat);
    end
  endtask

  initial begin
    reset    = 1'b1;
    exHold   = 1'b0;
    regStart = 1'b0;
    regValRs = 32'd0;
    regValRt = 32'd0;
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_hold();
    test_ignore();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
